// File: rtl/voltage_avg_mc_if.sv
// XADC sample stream into the multi-channel averager and the averaged voltage words out of it.
// xadc_valid qualifies xadc_data/xadc_channel for exactly one cycle. There is no ready: a sample is either accepted or dropped, and the source never stalls.
interface voltage_avg_mc_if #(
  parameter int IN_W   = 16,
  parameter int DATA_W = 12,
  parameter int N_CH   = 2
);
  logic [IN_W-1:0]        xadc_data;
  logic [3:0]             xadc_channel;
  logic                   xadc_valid;
  logic                   clear;
  logic [N_CH*DATA_W-1:0] voltage;
  logic [N_CH-1:0]        voltage_valid;

  modport master (
    output xadc_data, xadc_channel, xadc_valid, clear,
    input  voltage, voltage_valid
  );

  modport slave (
    input  xadc_data, xadc_channel, xadc_valid, clear,
    output voltage, voltage_valid
  );
endinterface

// File: rtl/voltage_avg_mc.sv
// Per-channel XADC averager with prescaler rate limiting.
// The block-average mode decimates. The EMA mode updates the output on every accepted sample.
module voltage_avg_mc #(
  parameter int IN_W         = 16,
  parameter int DATA_W       = 12,
  parameter int N_CH         = 2,
  parameter int LOG2_SAMPLES = 4,
  parameter int SAMPLE_DIV   = 1000,
  parameter int AVG_MODE     = 0
) (
  input  logic             clock,
  input  logic             reset,
  voltage_avg_mc_if.slave  bus
);
  localparam int AW = DATA_W + LOG2_SAMPLES;
  localparam int CW = (LOG2_SAMPLES > 0) ? LOG2_SAMPLES : 1;

  logic                   tick;
  logic [DATA_W-1:0]      sample;
  logic [N_CH*DATA_W-1:0] volt_flat;
  logic [N_CH-1:0]        vld_flat;
  logic                   unused_sink;

  assign sample      = bus.xadc_data[IN_W-1 -: DATA_W];
  assign unused_sink = ^{bus.xadc_data, tick};

  generate
    if (SAMPLE_DIV > 0) begin : g_presc
      localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
      logic [PW-1:0] presc_cnt;

      always_ff @(posedge clock or posedge reset) begin
        if (reset)
          presc_cnt <= '0;
        else if (presc_cnt == PW'(SAMPLE_DIV - 1))
          presc_cnt <= '0;
        else
          presc_cnt <= presc_cnt + PW'(1);
      end

      assign tick = (presc_cnt == PW'(SAMPLE_DIV - 1));
    end else begin : g_no_presc
      assign tick = 1'b0;
    end
  endgenerate

  generate
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
      logic              hit;
      logic              pend;
      logic              accept;
      logic [AW-1:0]     acc;
      logic [DATA_W-1:0] volt_q;
      logic              vld_q;

      // An out-of-range tag never matches any channel, so it is dropped without extra logic.
      assign hit    = bus.xadc_valid && (bus.xadc_channel == 4'(c));
      assign accept = hit && pend;

      if (SAMPLE_DIV > 0) begin : g_pend
        // A tick re-arms the flag even when it lands on an accept.
        always_ff @(posedge clock or posedge reset) begin
          if (reset)          pend <= 1'b0;
          else if (bus.clear) pend <= 1'b0;
          else if (tick)      pend <= 1'b1;
          else if (accept)    pend <= 1'b0;
        end
      end else begin : g_no_pend
        assign pend = 1'b1;
      end

      if (AVG_MODE == 0) begin : g_block
        logic [CW-1:0] cnt;
        logic [AW-1:0] acc_sum;
        logic          last;

        assign acc_sum = acc + AW'(sample);
        assign last    = (LOG2_SAMPLES == 0) || (cnt == {CW{1'b1}});

        always_ff @(posedge clock or posedge reset) begin
          if (reset) begin
            acc    <= '0;
            cnt    <= '0;
            volt_q <= '0;
            vld_q  <= 1'b0;
          end else begin
            vld_q <= 1'b0;
            if (bus.clear) begin
              acc <= '0;
              cnt <= '0;
            end else if (accept) begin
              if (last) begin
                volt_q <= DATA_W'(acc_sum >> LOG2_SAMPLES);
                acc    <= '0;
                cnt    <= '0;
                vld_q  <= 1'b1;
              end else begin
                acc <= acc_sum;
                cnt <= cnt + CW'(1);
              end
            end
          end
        end
      end else begin : g_ema
        logic          primed;
        logic [AW-1:0] acc_ema;

        // acc holds y << L, so the decay term is acc >> L.
        assign acc_ema = acc - (acc >> LOG2_SAMPLES) + AW'(sample);

        always_ff @(posedge clock or posedge reset) begin
          if (reset) begin
            acc    <= '0;
            primed <= 1'b0;
            volt_q <= '0;
            vld_q  <= 1'b0;
          end else begin
            vld_q <= 1'b0;
            if (bus.clear) begin
              acc    <= '0;
              primed <= 1'b0;
            end else if (accept) begin
              vld_q <= 1'b1;
              if (!primed) begin
                acc    <= AW'(sample) << LOG2_SAMPLES;
                volt_q <= sample;
                primed <= 1'b1;
              end else begin
                acc    <= acc_ema;
                volt_q <= DATA_W'(acc_ema >> LOG2_SAMPLES);
              end
            end
          end
        end
      end

      assign volt_flat[c*DATA_W +: DATA_W] = volt_q;
      assign vld_flat[c]                   = vld_q;
    end
  endgenerate

  assign bus.voltage       = volt_flat;
  assign bus.voltage_valid = vld_flat;
endmodule

// File: tb/tb_voltage_avg_mc.sv
// Directed bench for voltage_avg_mc. Four configurations share one clock and one reset:
// block L=4, block L=2, prescaled passthrough, and EMA L=2.
module tb_voltage_avg_mc;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  voltage_avg_mc_if #(.IN_W(16), .DATA_W(12), .N_CH(2)) b4_if ();
  voltage_avg_mc_if #(.IN_W(16), .DATA_W(12), .N_CH(2)) b2_if ();
  voltage_avg_mc_if #(.IN_W(16), .DATA_W(12), .N_CH(2)) dv_if ();
  voltage_avg_mc_if #(.IN_W(16), .DATA_W(12), .N_CH(2)) em_if ();

  voltage_avg_mc #(.IN_W(16), .DATA_W(12), .N_CH(2), .LOG2_SAMPLES(4), .SAMPLE_DIV(0), .AVG_MODE(0))
    u_b4 (.clock(clock), .reset(reset), .bus(b4_if.slave));
  voltage_avg_mc #(.IN_W(16), .DATA_W(12), .N_CH(2), .LOG2_SAMPLES(2), .SAMPLE_DIV(0), .AVG_MODE(0))
    u_b2 (.clock(clock), .reset(reset), .bus(b2_if.slave));
  voltage_avg_mc #(.IN_W(16), .DATA_W(12), .N_CH(2), .LOG2_SAMPLES(0), .SAMPLE_DIV(10), .AVG_MODE(0))
    u_dv (.clock(clock), .reset(reset), .bus(dv_if.slave));
  voltage_avg_mc #(.IN_W(16), .DATA_W(12), .N_CH(2), .LOG2_SAMPLES(2), .SAMPLE_DIV(0), .AVG_MODE(1))
    u_em (.clock(clock), .reset(reset), .bus(em_if.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_b4(input logic [3:0] ch, input logic [15:0] d);
    b4_if.xadc_channel = ch;
    b4_if.xadc_data    = d;
    b4_if.xadc_valid   = 1'b1;
    @(posedge clock); #1;
    b4_if.xadc_valid   = 1'b0;
  endtask

  task automatic drive_b2(input logic [3:0] ch, input logic [15:0] d);
    b2_if.xadc_channel = ch;
    b2_if.xadc_data    = d;
    b2_if.xadc_valid   = 1'b1;
    @(posedge clock); #1;
    b2_if.xadc_valid   = 1'b0;
  endtask

  task automatic drive_em(input logic [3:0] ch, input logic [15:0] d);
    em_if.xadc_channel = ch;
    em_if.xadc_data    = d;
    em_if.xadc_valid   = 1'b1;
    @(posedge clock); #1;
    em_if.xadc_valid   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    int n;
    int pulses;

    b4_if.xadc_data = '0; b4_if.xadc_channel = '0; b4_if.xadc_valid = 1'b0; b4_if.clear = 1'b0;
    b2_if.xadc_data = '0; b2_if.xadc_channel = '0; b2_if.xadc_valid = 1'b0; b2_if.clear = 1'b0;
    dv_if.xadc_data = '0; dv_if.xadc_channel = '0; dv_if.xadc_valid = 1'b0; dv_if.clear = 1'b0;
    em_if.xadc_data = '0; em_if.xadc_channel = '0; em_if.xadc_valid = 1'b0; em_if.clear = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    check("rst_b4_v",   32'(b4_if.voltage), 32'h0);
    check("rst_b4_vld", 32'(b4_if.voltage_valid), 32'h0);
    check("rst_em_v",   32'(em_if.voltage), 32'h0);

    // Block L=4: 16 x 0x1230 on ch0
    for (int i = 0; i < 15; i++) drive_b4(4'd0, 16'h1230);
    check("t1_vld_early", 32'(b4_if.voltage_valid), 32'h0);
    check("t1_v_early",   32'(b4_if.voltage), 32'h0);
    drive_b4(4'd0, 16'h1230);
    check("t1_v",   32'(b4_if.voltage), 32'h000123);
    check("t1_vld", 32'(b4_if.voltage_valid), 32'h1);
    @(posedge clock); #1;
    check("t1_vld_single", 32'(b4_if.voltage_valid), 32'h0);

    // Block L=2: truncation, then full scale without overflow
    drive_b2(4'd1, 16'h0010);
    drive_b2(4'd1, 16'h0020);
    drive_b2(4'd1, 16'h0030);
    drive_b2(4'd1, 16'h0050);
    check("t2_trunc_v",   32'(b2_if.voltage), 32'h002000);
    check("t2_trunc_vld", 32'(b2_if.voltage_valid), 32'h2);
    for (int i = 0; i < 4; i++) drive_b2(4'd1, 16'hFFF0);
    check("t2_full_v", 32'(b2_if.voltage), 32'hFFF000);

    // Prescaler 10: sync on the second pulse, which lands on the edge after counter==0
    dv_if.xadc_channel = 4'd0;
    dv_if.xadc_data    = 16'h0110;
    dv_if.xadc_valid   = 1'b1;
    seen = 0;
    n    = 0;
    while (seen < 2 && n < 40) begin
      @(posedge clock); #1;
      n++;
      if (dv_if.voltage_valid[0]) seen++;
    end
    check("t3_sync", 32'(seen), 32'd2);
    check("t3_sync_v", 32'(dv_if.voltage), 32'h000011);
    dv_if.xadc_valid = 1'b0;
    repeat (18) @(posedge clock);
    #1;
    // Counter is now at 9 with the flag armed: this accept coincides with the tick
    dv_if.xadc_data  = 16'h0AA0;
    dv_if.xadc_valid = 1'b1;
    @(posedge clock); #1;
    check("t3_tick_acc_vld", 32'(dv_if.voltage_valid), 32'h1);
    check("t3_tick_acc_v",   32'(dv_if.voltage), 32'h0000AA);
    dv_if.xadc_data = 16'h0BB0;
    @(posedge clock); #1;
    check("t3_rearm_vld", 32'(dv_if.voltage_valid), 32'h1);
    check("t3_rearm_v",   32'(dv_if.voltage), 32'h0000BB);
    dv_if.xadc_data = 16'h0CC0;
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clock); #1;
      if (dv_if.voltage_valid[0]) pulses++;
    end
    check("t3_quiet", 32'(pulses), 32'd0);
    @(posedge clock); #1;
    check("t3_next_vld", 32'(dv_if.voltage_valid), 32'h1);
    check("t3_next_v",   32'(dv_if.voltage), 32'h0000CC);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (dv_if.voltage_valid[0]) pulses++;
    end
    check("t3_rate", 32'(pulses), 32'd2);
    dv_if.xadc_valid = 1'b0;

    // EMA L=2: 100 -> 100, 200 -> 125, 200 -> 143
    drive_em(4'd0, 16'd1600);
    check("t4_first_v",   32'(em_if.voltage), 32'd100);
    check("t4_first_vld", 32'(em_if.voltage_valid), 32'h1);
    drive_em(4'd0, 16'd3200);
    check("t4_second_v",   32'(em_if.voltage), 32'd125);
    check("t4_second_vld", 32'(em_if.voltage_valid), 32'h1);
    drive_em(4'd0, 16'd3200);
    check("t4_third_v", 32'(em_if.voltage), 32'd143);
    em_if.clear = 1'b1;
    @(posedge clock); #1;
    em_if.clear = 1'b0;
    check("t4_clear_hold", 32'(em_if.voltage), 32'd143);
    check("t4_clear_vld",  32'(em_if.voltage_valid), 32'h0);
    drive_em(4'd0, 16'd640);
    check("t4_reprime_v", 32'(em_if.voltage), 32'd40);

    // Clear mid-block (with a colliding sample), then an out-of-range tag
    for (int i = 0; i < 5; i++) drive_b4(4'd0, 16'h5000);
    b4_if.clear = 1'b1;
    drive_b4(4'd0, 16'hF000);
    b4_if.clear = 1'b0;
    check("t6_clear_hold", 32'(b4_if.voltage), 32'h000123);
    check("t6_clear_vld",  32'(b4_if.voltage_valid), 32'h0);
    drive_b4(4'd3, 16'hF000);
    check("t6_tag3_vld", 32'(b4_if.voltage_valid), 32'h0);
    check("t6_tag3_v",   32'(b4_if.voltage), 32'h000123);
    for (int i = 0; i < 8; i++) drive_b4(4'd0, 16'h1000);
    for (int i = 0; i < 7; i++) drive_b4(4'd0, 16'h2000);
    check("t6_no_early", 32'(b4_if.voltage_valid), 32'h0);
    drive_b4(4'd0, 16'h2000);
    check("t6_avg_v",   32'(b4_if.voltage), 32'h000180);
    check("t6_avg_vld", 32'(b4_if.voltage_valid), 32'h1);

    // Asynchronous reset mid-block
    for (int i = 0; i < 7; i++) drive_b4(4'd0, 16'h0AB0);
    #2 reset = 1'b1;
    #1;
    check("t5_async_v",   32'(b4_if.voltage), 32'h0);
    check("t5_async_vld", 32'(b4_if.voltage_valid), 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 15; i++) drive_b4(4'd0, 16'h0AB0);
    check("t5_partial_vld", 32'(b4_if.voltage_valid), 32'h0);
    check("t5_partial_v",   32'(b4_if.voltage), 32'h0);
    drive_b4(4'd0, 16'h0AB0);
    check("t5_fresh_v",   32'(b4_if.voltage), 32'h0000AB);
    check("t5_fresh_vld", 32'(b4_if.voltage_valid), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
